instr_fetch_unit: RTL and testbench

Fetch stage that feeds the 3-bit-opcode control unit of the 8-bit processor. It holds the program counter and issues requests to instruction memory over a variable-latency request/valid handshake. It latches each returned 16-bit word into an instruction register and presents the decoded fields (opCode, rd, rs, rt, imm) to the control unit and register file under a valid/ready handshake. It also handles halt requests and a memory-timeout error.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/instr_fetch_unit_if.sv | 33 +++
 rtl/instr_field_split.sv | 19 +
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor front end: opcode values,
// instruction field positions and the fetch FSM state encoding.
package cpu_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_MOV   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_STORE = 3'b111;

    // imm deliberately overlaps rs/rt; which view is used depends on the opcode
    localparam int OPC_MSB = 15;
    localparam int RD_MSB  = 12;
    localparam int RS_MSB  = 9;
    localparam int RT_MSB  = 6;
    localparam int IMM_MSB = 7;

    localparam int OPC_W = 3;
    localparam int REG_W = 3;
    localparam int IMM_W = 8;

    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_REQ   = 3'd1,
        FETCH_WAIT  = 3'd2,
        FETCH_ISSUE = 3'd3,
        FETCH_HALT  = 3'd4
    } fetchState_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory handshake and the decoded-instruction
// handshake towards the control unit / register file.
interface instr_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
);

    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   imem_valid;

    logic                   instr_valid;
    logic                   instr_ready;
    logic [OPC_W-1:0]       opCode;
    logic [REG_W-1:0]       rd;
    logic [REG_W-1:0]       rs;
    logic [REG_W-1:0]       rt;
    logic [IMM_W-1:0]       imm;

    modport master (
        output imem_req, imem_addr, instr_valid, opCode, rd, rs, rt, imm,
        input  imem_rdata, imem_valid, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, opCode, rd, rs, rt, imm,
        output imem_rdata, imem_valid, instr_ready
    );

endinterface

// File: rtl/instr_field_split.sv
// Purely combinational split of a 16-bit instruction word into its fields.
module instr_field_split
    import cpu_pkg::*;
(
    input  logic [15:0]      ir,
    output logic [OPC_W-1:0] opCode,
    output logic [REG_W-1:0] rd,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt,
    output logic [IMM_W-1:0] imm
);

    assign opCode = ir[OPC_MSB -: OPC_W];
    assign rd     = ir[RD_MSB  -: REG_W];
    assign rs     = ir[RS_MSB  -: REG_W];
    assign rt     = ir[RT_MSB  -: REG_W];
    assign imm    = ir[IMM_MSB -: IMM_W];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one request at a time to instruction
// memory, holds the returned word and offers it downstream until accepted.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  TIMEOUT     = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt_req,
    instr_fetch_unit_if.master  bus,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                fetch_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    fetchState_t            stateReg, stateNext;
    logic [PC_WIDTH-1:0]    pcReg, pcNext;
    logic [INSTR_WIDTH-1:0] irReg, irNext;
    logic [7:0]             waitCntReg, waitCntNext;
    logic                   haltPendReg, haltPendNext;
    logic                   fetchErrReg, fetchErrNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= FETCH_IDLE;
            pcReg       <= RESET_PC;
            irReg       <= '0;
            waitCntReg  <= '0;
            haltPendReg <= 1'b0;
            fetchErrReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            pcReg       <= pcNext;
            irReg       <= irNext;
            waitCntReg  <= waitCntNext;
            haltPendReg <= haltPendNext;
            fetchErrReg <= fetchErrNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        pcNext       = pcReg;
        irNext       = irReg;
        waitCntNext  = waitCntReg;
        haltPendNext = haltPendReg | halt_req;
        fetchErrNext = fetchErrReg;

        case (stateReg)
            FETCH_IDLE, FETCH_HALT: begin
                // start always buys one instruction, even if halt_req arrives with it
                if (start) begin
                    stateNext    = FETCH_REQ;
                    haltPendNext = halt_req;
                    fetchErrNext = 1'b0;
                end
            end
            FETCH_REQ: begin
                waitCntNext = '0;
                stateNext   = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                waitCntNext = waitCntReg + 8'd1;
                if (bus.imem_valid) begin
                    irNext    = bus.imem_rdata;
                    stateNext = FETCH_ISSUE;
                end else if (waitCntNext == TIMEOUT_CNT) begin
                    fetchErrNext = 1'b1;
                    stateNext    = FETCH_HALT;
                end
            end
            FETCH_ISSUE: begin
                if (bus.instr_ready) begin
                    pcNext    = pcReg + PC_WIDTH'(1);
                    stateNext = haltPendNext ? FETCH_HALT : FETCH_REQ;
                end
            end
            default: stateNext = FETCH_IDLE;
        endcase
    end

    assign bus.imem_req    = (stateReg == FETCH_REQ);
    assign bus.imem_addr   = pcReg;
    assign bus.instr_valid = (stateReg == FETCH_ISSUE);
    assign pc              = pcReg;
    assign halted          = (stateReg == FETCH_HALT);
    assign fetch_err       = fetchErrReg;

    instr_field_split fieldSplit (
        .ir     (irReg),
        .opCode (bus.opCode),
        .rd     (bus.rd),
        .rs     (bus.rs),
        .rt     (bus.rt),
        .imm    (bus.imm)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transaction-level reference model
// and a latency-programmable instruction memory responder.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       halt_req = 1'b0;
    logic [7:0] pc;
    logic       halted;
    logic       fetch_err;

    instr_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();

    instr_fetch_unit #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (16),
        .RESET_PC    (8'h00),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .halt_req  (halt_req),
        .bus       (bus),
        .pc        (pc),
        .halted    (halted),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory responder ----------------
    logic [15:0] mem [256];
    int          respLat = 2;
    bit          memSilent = 1'b0;
    int          pendCnt = 0;
    logic [7:0]  reqAddr = '0;
    int          reqCount = 0;

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'hDEAD;
        forever begin
            @(negedge clk);
            bus.imem_valid = 1'b0;
            bus.imem_rdata = 16'hDEAD;
            if (pendCnt > 0) begin
                pendCnt--;
                if (pendCnt == 0 && !memSilent) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = mem[reqAddr];
                end
            end
            if (bus.imem_req === 1'b1) begin
                pendCnt  = respLat;
                reqAddr  = bus.imem_addr;
                reqCount++;
            end
        end
    end

    // ---------------- reference model (what the unit should be doing) ----------------
    bit          mIdle = 1'b1, mReq = 1'b0, mAwait = 1'b0, mOffer = 1'b0;
    bit          mHalt = 1'b0, mErr = 1'b0, mPend = 1'b0;
    int          mWaited = 0;
    int          mPc = 0;
    logic [15:0] mWord = '0;

    initial begin
        bit pendNow;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mIdle = 1; mReq = 0; mAwait = 0; mOffer = 0;
                mHalt = 0; mErr = 0; mPend = 0; mWaited = 0; mPc = 0;
            end else begin
                pendNow = mPend || (halt_req === 1'b1);
                if (mIdle || mHalt) begin
                    if (start) begin
                        mIdle = 0; mHalt = 0; mErr = 0; mReq = 1; mPend = halt_req;
                    end else begin
                        mPend = pendNow;
                    end
                end else if (mReq) begin
                    mReq = 0; mAwait = 1; mWaited = 0; mPend = pendNow;
                end else if (mAwait) begin
                    mPend = pendNow;
                    mWaited++;
                    if (bus.imem_valid) begin
                        mAwait = 0; mOffer = 1; mWord = bus.imem_rdata;
                    end else if (mWaited == TO) begin
                        mAwait = 0; mHalt = 1; mErr = 1;
                    end
                end else if (mOffer) begin
                    mPend = pendNow;
                    if (bus.instr_ready) begin
                        mOffer = 0;
                        mPc = (mPc + 1) % 256;
                        if (pendNow) mHalt = 1;
                        else         mReq = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        int w;
        forever begin
            @(negedge clk);
            #1;
            w = int'(mWord);
            check("imem_req", 32'(bus.imem_req), 32'(mReq));
            if (mReq || mAwait) check("imem_addr", 32'(bus.imem_addr), 32'(mPc));
            check("instr_valid", 32'(bus.instr_valid), 32'(mOffer));
            if (mOffer) begin
                check("opCode", 32'(bus.opCode), 32'((w >> 13) & 7));
                check("rd",     32'(bus.rd),     32'((w >> 10) & 7));
                check("rs",     32'(bus.rs),     32'((w >> 7) & 7));
                check("rt",     32'(bus.rt),     32'((w >> 4) & 7));
                check("imm",    32'(bus.imm),    32'(w & 255));
            end
            check("pc", 32'(pc), 32'(mPc));
            check("halted", 32'(halted), 32'(mHalt));
            check("fetch_err", 32'(fetch_err), 32'(mErr));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitValid(input int limit);
        int k = 0;
        while (bus.instr_valid !== 1'b1 && k < limit) begin @(negedge clk); k++; end
        if (bus.instr_valid !== 1'b1) check("wait_instr_valid", 32'(bus.instr_valid), 32'd1);
    endtask

    task automatic waitReq(input int limit);
        int k = 0;
        while (bus.imem_req !== 1'b1 && k < limit) begin @(negedge clk); k++; end
        if (bus.imem_req !== 1'b1) check("wait_imem_req", 32'(bus.imem_req), 32'd1);
    endtask

    task automatic checkCleared(input string tag);
        check({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_imem_req"},    32'(bus.imem_req),    32'd0);
        check({tag, "_halted"},      32'(halted),          32'd0);
        check({tag, "_fetch_err"},   32'(fetch_err),       32'd0);
        check({tag, "_pc"},          32'(pc),              32'd0);
        check({tag, "_opCode"},      32'(bus.opCode),      32'd0);
        check({tag, "_rd"},          32'(bus.rd),          32'd0);
        check({tag, "_rs"},          32'(bus.rs),          32'd0);
        check({tag, "_rt"},          32'(bus.rt),          32'd0);
        check({tag, "_imm"},         32'(bus.imm),         32'd0);
    endtask

    initial begin
        int n;
        int reqBefore;
        logic [7:0] prevPc;

        for (int i = 0; i < 256; i++) mem[i] = 16'((i * 40503) ^ 16'h5A5A);
        mem[0] = 16'h4A90;
        bus.instr_ready = 1'b0;

        // Reset state
        cyc(3);
        checkCleared("reset");
        rst_n = 1'b1;
        cyc(2);
        check("idle_no_req", 32'(bus.imem_req), 32'd0);

        // 1: first fetch, latency 2, 16'h4A90 -> ADD r2, r5, r1 / imm 0x90
        respLat = 2;
        bus.instr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_req", 32'(bus.imem_req), 32'd1);
        check("t1_addr", 32'(bus.imem_addr), 32'd0);
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("t1_req_to_issue", 32'(n), 32'd3);
        check("t1_opCode", 32'(bus.opCode), 32'(OP_ADD));
        check("t1_rd", 32'(bus.rd), 32'd2);
        check("t1_rs", 32'(bus.rs), 32'd5);
        check("t1_rt", 32'(bus.rt), 32'd1);
        check("t1_imm", 32'(bus.imm), 32'h90);
        @(negedge clk);
        check("t1_pc_after", 32'(pc), 32'd1);
        bus.instr_ready = 1'b0;

        // 2: backpressure for 5 cycles, accept on the 6th
        waitValid(20);
        reqBefore = reqCount;
        repeat (5) begin
            @(negedge clk);
            check("t2_valid_held", 32'(bus.instr_valid), 32'd1);
            check("t2_pc_held", 32'(pc), 32'd1);
        end
        check("t2_no_req", 32'(reqCount - reqBefore), 32'd0);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check("t2_pc_after", 32'(pc), 32'd2);

        // 3: run straight through to the PC wrap
        respLat = 1;
        prevPc = pc;
        n = 0;
        while (pc !== 8'h00 && n < 1200) begin prevPc = pc; @(negedge clk); n++; end
        check("t3_wrapped_pc", 32'(pc), 32'd0);
        check("t3_prev_pc", 32'(prevPc), 32'hFF);
        waitReq(5);
        check("t3_addr_after_wrap", 32'(bus.imem_addr), 32'd0);

        // 4a: latency exactly TIMEOUT still succeeds
        waitValid(10);
        respLat = TO;
        waitReq(5);
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("t4_lat15_issue", 32'(n), 32'd16);
        check("t4_lat15_err", 32'(fetch_err), 32'd0);
        memSilent = 1'b1;

        // 4b: memory silent -> timeout, sticky error, halted
        waitReq(5);
        n = 0;
        while (halted !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("t4_timeout_cycles", 32'(n), 32'd16);
        check("t4_fetch_err", 32'(fetch_err), 32'd1);
        check("t4_pc_unchanged", 32'(pc), 32'd2);
        cyc(3);
        check("t4_err_sticky", 32'(fetch_err), 32'd1);
        memSilent = 1'b0;
        respLat = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_err_cleared", 32'(fetch_err), 32'd0);
        check("t4_rereq", 32'(bus.imem_req), 32'd1);
        check("t4_rereq_addr", 32'(bus.imem_addr), 32'd2);

        // 5: halt_req pulsed during WAIT -> word still issues, then HALT
        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        waitValid(10);
        @(negedge clk);
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_pc", 32'(pc), 32'd3);
        reqBefore = reqCount;
        cyc(8);
        check("t5_no_more_req", 32'(reqCount - reqBefore), 32'd0);

        // 5b: start together with halt_req in HALT -> exactly one instruction
        start = 1'b1;
        halt_req = 1'b1;
        @(negedge clk);
        start = 1'b0;
        halt_req = 1'b0;
        check("t5b_req", 32'(bus.imem_req), 32'd1);
        check("t5b_addr", 32'(bus.imem_addr), 32'd3);
        waitValid(10);
        @(negedge clk);
        check("t5b_halted", 32'(halted), 32'd1);
        check("t5b_pc", 32'(pc), 32'd4);

        // 6: reset mid-WAIT, late imem_valid one cycle after release
        respLat = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_req", 32'(bus.imem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkCleared("t6");
        end

        // Recovery after reset: fetch from RESET_PC again
        respLat = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitValid(10);
        check("t7_opCode", 32'(bus.opCode), 32'(OP_ADD));
        check("t7_imm", 32'(bus.imm), 32'h90);
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
